// File: rtl/pic_inta_sequencer.sv
// CPU-side 8259 interrupt-acknowledge sequencer: two-pulse INTA cycle, vector capture, valid/ready hand-off.
// Optional PIC_INTA_STATS_EN adds saturating ack_count/spur_count outputs.
module pic_inta_sequencer #(
    parameter int unsigned PULSE_W = 4,
    parameter int unsigned GAP_W   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pic_int,
    input  logic        enable,
    input  logic [7:0]  pic_data,
    output logic        pic_inta_n,
    output logic        vec_valid,
    output logic [7:0]  vec_data,
    input  logic        vec_ready,
    output logic        busy,
    output logic        spurious
`ifdef PIC_INTA_STATS_EN
    ,
    output logic [15:0] ack_count,
    output logic [15:0] spur_count
`endif
);

    localparam int unsigned MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int unsigned CW    = $clog2(MAX_W + 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        P1_LOW,
        GAP1,
        P2_LOW,
        HOLD,
        RECOVER
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          int_meta;
    logic          int_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_meta <= 1'b0;
            int_s    <= 1'b0;
        end else begin
            int_meta <= pic_int;
            int_s    <= int_meta;
        end
    end

    // Outputs are registered from the next state, so each pulse width is exactly the count loaded on entry plus one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            pic_inta_n <= 1'b1;
            vec_valid  <= 1'b0;
            vec_data   <= '0;
            busy       <= 1'b0;
            spurious   <= 1'b0;
        end else begin
            spurious <= 1'b0;
            case (state)
                IDLE: begin
                    if (int_s && enable) begin
                        state <= SYNC;
                        busy  <= 1'b1;
                    end
                end
                SYNC: begin
                    if (int_s) begin
                        state      <= P1_LOW;
                        cnt        <= PULSE_LD;
                        pic_inta_n <= 1'b0;
                    end else begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        spurious <= 1'b1;
                    end
                end
                P1_LOW: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state      <= GAP1;
                        cnt        <= GAP_LD;
                        pic_inta_n <= 1'b1;
                    end
                end
                GAP1: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state      <= P2_LOW;
                        cnt        <= PULSE_LD;
                        pic_inta_n <= 1'b0;
                    end
                end
                P2_LOW: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state      <= HOLD;
                        pic_inta_n <= 1'b1;
                        vec_data   <= pic_data;
                        vec_valid  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (vec_ready) begin
                        state     <= RECOVER;
                        cnt       <= GAP_LD;
                        vec_valid <= 1'b0;
                    end
                end
                RECOVER: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    pic_inta_n <= 1'b1;
                    vec_valid  <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIC_INTA_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_count  <= '0;
            spur_count <= '0;
        end else begin
            if (state == HOLD && vec_ready && ack_count != 16'hFFFF)
                ack_count <= ack_count + 16'd1;
            if (state == SYNC && !int_s && spur_count != 16'hFFFF)
                spur_count <= spur_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed bench for pic_inta_sequencer: timeline model checked every cycle plus hand-computed literal checks.
module tb_pic_inta_sequencer;

    localparam int P = 4;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pic_int = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] pic_data = 8'h00;
    logic       vec_ready = 1'b0;
    logic       pic_inta_n;
    logic       vec_valid;
    logic [7:0] vec_data;
    logic       busy;
    logic       spurious;
`ifdef PIC_INTA_STATS_EN
    logic [15:0] ack_count;
    logic [15:0] spur_count;
`endif

    pic_inta_sequencer #(.PULSE_W(P), .GAP_W(G)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pic_int    (pic_int),
        .enable     (enable),
        .pic_data   (pic_data),
        .pic_inta_n (pic_inta_n),
        .vec_valid  (vec_valid),
        .vec_data   (vec_data),
        .vec_ready  (vec_ready),
        .busy       (busy),
        .spurious   (spurious)
`ifdef PIC_INTA_STATS_EN
        ,
        .ack_count  (ack_count),
        .spur_count (spur_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Timeline model: ph 0=idle 1=qualifying 2=acknowledging 3=presenting 4=recovering.
    int         cyc = 0;
    int         ph = 0;
    int         s_t = 0;
    int         r_t = 0;
    int         spur_edge = -1;
    bit         m_s1 = 0;
    bit         m_s2 = 0;
    logic [7:0] m_vec = 8'h00;
    int         m_ack = 0;
    int         m_spur = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph = 0; m_s1 = 0; m_s2 = 0; spur_edge = -1; m_vec = 8'h00;
            m_ack = 0; m_spur = 0;
        end else begin
            cyc = cyc + 1;
            case (ph)
                0: if (m_s2 && enable) ph = 1;
                1: if (m_s2) begin ph = 2; s_t = cyc; end
                   else begin ph = 0; spur_edge = cyc; if (m_spur < 65535) m_spur++; end
                2: if (cyc == s_t + 2*P + G) begin ph = 3; m_vec = pic_data; end
                3: if (vec_ready) begin ph = 4; r_t = cyc; if (m_ack < 65535) m_ack++; end
                4: if (cyc == r_t + G) ph = 0;
                default: ph = 0;
            endcase
            m_s2 = m_s1;
            m_s1 = pic_int;
        end
    end

    always @(negedge clk) begin
        int  d;
        logic exp_inta;
        d = cyc - s_t;
        exp_inta = !(ph == 2 && (d < P || d >= P + G));
        chk("cmp_inta_n", pic_inta_n, exp_inta);
        chk("cmp_vec_valid", vec_valid, ph == 3);
        chk("cmp_vec_data", vec_data, m_vec);
        chk("cmp_busy", busy, ph != 0);
        chk("cmp_spurious", spurious, rst_n && spur_edge == cyc);
`ifdef PIC_INTA_STATS_EN
        chk("cmp_ack_count", ack_count, m_ack[15:0]);
        chk("cmp_spur_count", spur_count, m_spur[15:0]);
`endif
    end

    task automatic at_edge(input int e);
        int guard = 0;
        while (cyc < e && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        chk("edge_reached", cyc >= e, 1'b1);
    endtask

    task automatic start(input logic [7:0] d, input logic rdy, output int e0);
        @(negedge clk);
        pic_int = 1'b1;
        pic_data = d;
        vec_ready = rdy;
        e0 = cyc + 1;
    endtask

    task automatic settle();
        int guard = 0;
        @(negedge clk);
        pic_int = 1'b0;
        vec_ready = 1'b1;
        repeat (4) @(negedge clk);
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("settle_idle", busy, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int e0;
        repeat (3) @(negedge clk);
        chk("rst_inta_n", pic_inta_n, 1'b1);
        chk("rst_vec_valid", vec_valid, 1'b0);
        chk("rst_vec_data", vec_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_spurious", spurious, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset during second pulse, then restart from IDLE
        start(8'h11, 1'b1, e0);
        at_edge(e0 + 10);
        chk("t5_p2_low", pic_inta_n, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_inta", pic_inta_n, 1'b1);
        chk("t5_async_valid", vec_valid, 1'b0);
        chk("t5_async_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        e0 = cyc + 1;
        at_edge(e0 + 2);
        chk("t5_r2_busy", busy, 1'b1);
        chk("t5_r2_inta", pic_inta_n, 1'b1);
        at_edge(e0 + 3);
        chk("t5_r3_inta", pic_inta_n, 1'b0);
        at_edge(e0 + 13);
        chk("t5_valid", vec_valid, 1'b1);
        chk("t5_data", vec_data, 8'h11);
        settle();

        // Basic acknowledge with default latency
        start(8'h4B, 1'b1, e0);
        at_edge(e0 + 2);
        chk("t1_e2_busy", busy, 1'b1);
        chk("t1_e2_inta", pic_inta_n, 1'b1);
        at_edge(e0 + 3);  chk("t1_e3_inta", pic_inta_n, 1'b0);
        at_edge(e0 + 6);  chk("t1_e6_inta", pic_inta_n, 1'b0);
        at_edge(e0 + 7);  chk("t1_e7_inta", pic_inta_n, 1'b1);
        at_edge(e0 + 8);  chk("t1_e8_inta", pic_inta_n, 1'b1);
        at_edge(e0 + 9);  chk("t1_e9_inta", pic_inta_n, 1'b0);
        at_edge(e0 + 12); chk("t1_e12_valid", vec_valid, 1'b0);
        at_edge(e0 + 13);
        chk("t1_e13_valid", vec_valid, 1'b1);
        chk("t1_e13_data", vec_data, 8'h4B);
        chk("t1_e13_inta", pic_inta_n, 1'b1);
        @(negedge clk);
        pic_int = 1'b0;
        at_edge(e0 + 14);
        chk("t1_e14_valid", vec_valid, 1'b0);
        chk("t1_e14_busy", busy, 1'b1);
        at_edge(e0 + 15); chk("t1_e15_busy", busy, 1'b1);
        at_edge(e0 + 16); chk("t1_e16_busy", busy, 1'b0);
        settle();

        // Spurious: INT withdrawn before acknowledge starts
        @(negedge clk);
        pic_int = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        pic_int = 1'b0;
        at_edge(e0 + 2);
        chk("t2_e2_busy", busy, 1'b1);
        chk("t2_e2_spur", spurious, 1'b0);
        at_edge(e0 + 3);
        chk("t2_e3_spur", spurious, 1'b1);
        chk("t2_e3_busy", busy, 1'b0);
        chk("t2_e3_inta", pic_inta_n, 1'b1);
        at_edge(e0 + 4);
        chk("t2_e4_spur", spurious, 1'b0);
        chk("t2_e4_valid", vec_valid, 1'b0);
        settle();

        // INT dropped during GAP1: second pulse still issued
        start(8'h5C, 1'b1, e0);
        at_edge(e0 + 7);
        @(negedge clk);
        pic_int = 1'b0;
        at_edge(e0 + 9);  chk("t3_e9_inta", pic_inta_n, 1'b0);
        at_edge(e0 + 13);
        chk("t3_valid", vec_valid, 1'b1);
        chk("t3_data", vec_data, 8'h5C);
        settle();

        // CPU stalls for 20 cycles with INT still pending
        start(8'hA0, 1'b0, e0);
        at_edge(e0 + 13);
        chk("t4_valid", vec_valid, 1'b1);
        @(negedge clk);
        pic_data = 8'hFF;
        for (int i = 0; i < 20; i++) begin
            at_edge(e0 + 14 + i);
            chk("t4_hold_valid", vec_valid, 1'b1);
            chk("t4_hold_data", vec_data, 8'hA0);
            chk("t4_hold_inta", pic_inta_n, 1'b1);
        end
        settle();
`ifdef PIC_INTA_STATS_EN
        chk("stats_ack_4", ack_count, 16'd4);
        chk("stats_spur_1", spur_count, 16'd1);
`endif

        // enable low blocks new cycles
        @(negedge clk);
        enable = 1'b0;
        pic_int = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t6_busy", busy, 1'b0);
            chk("t6_inta", pic_inta_n, 1'b1);
        end
        pic_int = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        settle();
`ifdef PIC_INTA_STATS_EN
        chk("stats_ack_still_4", ack_count, 16'd4);
        chk("stats_spur_still_1", spur_count, 16'd1);
`endif

        // Back-to-back: pending INT restarts straight after RECOVER
        start(8'h33, 1'b1, e0);
        at_edge(e0 + 13); chk("t7_data1", vec_data, 8'h33);
        at_edge(e0 + 16); chk("t7_e16_busy", busy, 1'b0);
        at_edge(e0 + 17); chk("t7_e17_busy", busy, 1'b1);
        at_edge(e0 + 18); chk("t7_e18_inta", pic_inta_n, 1'b0);
        @(negedge clk);
        pic_int = 1'b0;
        pic_data = 8'h44;
        at_edge(e0 + 28);
        chk("t7_valid2", vec_valid, 1'b1);
        chk("t7_data2", vec_data, 8'h44);
        settle();
`ifdef PIC_INTA_STATS_EN
        chk("stats_ack_6", ack_count, 16'd6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
